// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU codes, forward selects,
// multiply FSM states and the E/M register bundle.
package exe_pkg;

  localparam logic [5:0] ALU_ADD    = 6'h00;
  localparam logic [5:0] ALU_SUB    = 6'h01;
  localparam logic [5:0] ALU_AND    = 6'h02;
  localparam logic [5:0] ALU_OR     = 6'h03;
  localparam logic [5:0] ALU_XOR    = 6'h04;
  localparam logic [5:0] ALU_SLT    = 6'h05;
  localparam logic [5:0] ALU_SLTU   = 6'h06;
  localparam logic [5:0] ALU_SLL    = 6'h07;
  localparam logic [5:0] ALU_SRL    = 6'h08;
  localparam logic [5:0] ALU_SRA    = 6'h09;
  localparam logic [5:0] ALU_MUL    = 6'h20;
  localparam logic [5:0] ALU_MAC    = 6'h21;
  localparam logic [5:0] ALU_MACCLR = 6'h22;

  localparam logic [1:0] FWD_RD   = 2'b00;
  localparam logic [1:0] FWD_RESW = 2'b01;
  localparam logic [1:0] FWD_ALUM = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } mac_state_t;

  function automatic int unsigned mul_steps(input int unsigned bpc);
    return 32 / bpc;
  endfunction

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        result_src;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [31:0] pc_plus4;
  } em_t;

endpackage

// File: rtl/iterative_mac_unit.sv
// Iterative shift-add multiplier with a 32-bit accumulator.
// Retires BITS_PER_CYCLE multiplier bits per RUN cycle.
module iterative_mac_unit
  import exe_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 2,
  parameter logic [31:0] RESET_ACC      = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_mac,
  input  logic        clr,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic [31:0] acc_result,
  output logic [31:0] acc_value
);

  localparam int unsigned STEPS = mul_steps(BITS_PER_CYCLE);
  localparam int          CW    = $clog2(STEPS + 1);

  mac_state_t  state, state_n;
  logic [CW-1:0] cnt;
  logic [31:0] mcand, mplier, prod, acc, step_sum;
  logic        mac_q;

  always_comb begin
    step_sum = prod;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier[i]) step_sum = step_sum + (mcand << i);
    end
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          busy    = 1'b1;
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (cnt == CW'(STEPS - 1)) state_n = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Operands are latched on entry so stalled forward paths cannot corrupt them
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      mac_q  <= 1'b0;
      acc    <= RESET_ACC;
    end else begin
      state <= state_n;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            prod   <= '0;
            cnt    <= '0;
            mac_q  <= is_mac;
          end else if (clr) begin
            acc <= '0;
          end
        end
        ST_RUN: begin
          prod   <= step_sum;
          mcand  <= mcand << BITS_PER_CYCLE;
          mplier <= mplier >> BITS_PER_CYCLE;
          cnt    <= cnt + 1'b1;
        end
        ST_DONE: begin
          if (mac_q) acc <= acc_result;
        end
        default: ;
      endcase
    end
  end

  assign product    = prod;
  assign acc_result = acc + prod;
  assign acc_value  = acc;

endmodule

// File: rtl/execute_cycle.sv
// RISC-V execute stage: forwarding, ALU, branch resolve,
// iterative MUL/MAC and the E/M pipeline register.
module execute_cycle
  import exe_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 2,
  parameter logic [31:0] RESET_ACC      = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        ALUSrcE,
  input  logic        MemWriteE,
  input  logic        ResultSrcE,
  input  logic        BranchE,
  input  logic [5:0]  ALUControlE,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] Imm_Ext_E,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RD_E,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        BusyE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        ResultSrcM,
  output logic [4:0]  RD_M,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M
);

  logic [31:0] src_a, src_b, write_data;
  logic [31:0] alu_result, ex_result;
  logic [31:0] product, acc_result, acc_value;
  logic        is_multi, is_mac, busy, mul_done;
  logic [4:0]  shamt;
  em_t         em_d, em_q;

  always_comb begin
    src_a = RD1_E;
    unique case (1'b1)
      (ForwardAE == FWD_RESW): src_a = ResultW;
      (ForwardAE == FWD_ALUM): src_a = ALUResultM;
      default:                 src_a = RD1_E;
    endcase
  end

  always_comb begin
    write_data = RD2_E;
    unique case (1'b1)
      (ForwardBE == FWD_RESW): write_data = ResultW;
      (ForwardBE == FWD_ALUM): write_data = ALUResultM;
      default:                 write_data = RD2_E;
    endcase
  end

  assign src_b     = ALUSrcE ? Imm_Ext_E : write_data;
  assign shamt     = src_b[4:0];
  assign PCSrcE    = BranchE & (src_a == src_b);
  assign PCTargetE = PCE + Imm_Ext_E;

  assign is_mac   = (ALUControlE == ALU_MAC);
  assign is_multi = (ALUControlE == ALU_MUL) | is_mac;

  always_comb begin
    alu_result = '0;
    unique case (ALUControlE)
      ALU_ADD:    alu_result = src_a + src_b;
      ALU_SUB:    alu_result = src_a - src_b;
      ALU_AND:    alu_result = src_a & src_b;
      ALU_OR:     alu_result = src_a | src_b;
      ALU_XOR:    alu_result = src_a ^ src_b;
      ALU_SLT:    alu_result = {31'b0, $signed(src_a) < $signed(src_b)};
      ALU_SLTU:   alu_result = {31'b0, src_a < src_b};
      ALU_SLL:    alu_result = src_a << shamt;
      ALU_SRL:    alu_result = src_a >> shamt;
      ALU_SRA:    alu_result = $unsigned($signed(src_a) >>> shamt);
      ALU_MACCLR: alu_result = acc_value;
      default:    alu_result = '0;
    endcase
  end

  iterative_mac_unit #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE),
    .RESET_ACC     (RESET_ACC)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .start     (is_multi),
    .is_mac    (is_mac),
    .clr       (ALUControlE == ALU_MACCLR),
    .a         (src_a),
    .b         (src_b),
    .busy      (busy),
    .done      (mul_done),
    .product   (product),
    .acc_result(acc_result),
    .acc_value (acc_value)
  );

  assign BusyE = busy;

  always_comb begin
    ex_result = alu_result;
    if (mul_done) ex_result = is_mac ? acc_result : product;
  end

  // A stalled E stage must not leak its instruction into M
  always_comb begin
    em_d = '0;
    if (!busy) begin
      em_d.reg_write  = RegWriteE;
      em_d.mem_write  = MemWriteE;
      em_d.result_src = ResultSrcE;
      em_d.rd         = RD_E;
      em_d.alu_result = ex_result;
      em_d.write_data = write_data;
      em_d.pc_plus4   = PCPlus4E;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) em_q <= '0;
    else     em_q <= em_d;
  end

  assign RegWriteM  = em_q.reg_write;
  assign MemWriteM  = em_q.mem_write;
  assign ResultSrcM = em_q.result_src;
  assign RD_M       = em_q.rd;
  assign ALUResultM = em_q.alu_result;
  assign WriteDataM = em_q.write_data;
  assign PCPlus4M   = em_q.pc_plus4;

endmodule

// File: tb/tb_execute_cycle.sv
// Directed self-checking bench for execute_cycle.
// Each task drives one scenario and checks inline.
module tb_execute_cycle;
  import exe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [5:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        PCSrcE, BusyE, RegWriteM, MemWriteM, ResultSrcM;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RD_M;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE),
    .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .RD_E(RD_E),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .BusyE(BusyE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .RD_M(RD_M), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    RegWriteE   = 1'b0; ALUSrcE    = 1'b0;
    MemWriteE   = 1'b0; ResultSrcE = 1'b0;
    BranchE     = 1'b0; ALUControlE = ALU_ADD;
    RD1_E       = '0;   RD2_E      = '0;
    Imm_Ext_E   = '0;   PCE        = '0;
    PCPlus4E    = '0;   RD_E       = '0;
    ForwardAE   = FWD_RD; ForwardBE = FWD_RD;
    ResultW     = '0;
  endtask

  // Issues one multi-cycle op and reports what the pipeline saw
  task automatic do_multi(
    input  logic [5:0]  op,
    input  logic [1:0]  fa,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  rd,
    output int          busy_n,
    output int          bub_bad,
    output logic [31:0] res,
    output logic        rw,
    output logic [4:0]  rdm
  );
    ALUControlE = op; ForwardAE = fa; ForwardBE = FWD_RD;
    RD1_E = a; RD2_E = b; ALUSrcE = 1'b0;
    RegWriteE = 1'b1; RD_E = rd; PCPlus4E = 32'h200;
    #1;
    busy_n = 0; bub_bad = 0;
    while (BusyE === 1'b1 && busy_n < 40) begin
      step();
      busy_n++;
      ResultW = ResultW + 32'h11;
      if (RegWriteM !== 1'b0 || ALUResultM !== '0 || RD_M !== '0)
        bub_bad++;
    end
    step();
    res = ALUResultM; rw = RegWriteM; rdm = RD_M;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    RegWriteE = 1'b1; RD_E = 5'd9; PCPlus4E = 32'h44;
    RD1_E = 32'h5; Imm_Ext_E = 32'h3; ALUSrcE = 1'b1;
    rst = 1'b1;
    step(); step();
    checks++;
    if ({RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM,
         WriteDataM, PCPlus4M} !== '0) begin
      errors++;
      $display("FAIL reset_em: RegWriteM=%0b RD_M=%0d ALUResultM=%h PCPlus4M=%h expected all 0",
               RegWriteM, RD_M, ALUResultM, PCPlus4M);
    end
    checks++;
    if (BusyE !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", BusyE);
    end
    rst = 1'b0;
    idle_inputs();
    step();
  endtask

  task automatic test_add();
    ALUControlE = ALU_ADD; RD1_E = 32'd5; Imm_Ext_E = 32'd7;
    ALUSrcE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd3;
    RD2_E = 32'h55; PCPlus4E = 32'h44;
    #1;
    checks++;
    if (BusyE !== 1'b0) begin
      errors++;
      $display("FAIL add_busy: got %b expected 0", BusyE);
    end
    step();
    checks++;
    if (ALUResultM !== 32'd12) begin
      errors++;
      $display("FAIL add_result: got %h expected %h", ALUResultM, 32'd12);
    end
    checks++;
    if (RD_M !== 5'd3 || RegWriteM !== 1'b1) begin
      errors++;
      $display("FAIL add_ctrl: RD_M=%0d RegWriteM=%b expected 3/1", RD_M, RegWriteM);
    end
    checks++;
    if (WriteDataM !== 32'h55 || PCPlus4M !== 32'h44) begin
      errors++;
      $display("FAIL add_data: WriteDataM=%h PCPlus4M=%h expected 55/44", WriteDataM, PCPlus4M);
    end
    checks++;
    if (BusyE !== 1'b0) begin
      errors++;
      $display("FAIL add_busy_after: got %b expected 0", BusyE);
    end
    idle_inputs();
  endtask

  task automatic test_alu_ops();
    logic [5:0]  ops [10] = '{ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT,
                              ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, 6'h0A};
    logic [31:0] av  [10] = '{32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,
                              32'h80000000, 32'h80000000, 32'd5};
    logic [31:0] bv  [10] = '{32'd7, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00,
                              32'd1, 32'd1, 32'd33, 32'd4, 32'd4, 32'd5};
    logic [31:0] ev  [10] = '{32'hFFFFFFFE, 32'hF000F000, 32'hFFF0FFF0,
                              32'h0FF00FF0, 32'd1, 32'd0, 32'd2,
                              32'h08000000, 32'hF8000000, 32'd0};
    for (int i = 0; i < 10; i++) begin
      ALUControlE = ops[i]; RD1_E = av[i]; RD2_E = bv[i];
      ALUSrcE = 1'b0; RegWriteE = 1'b1; RD_E = 5'd4;
      step();
      checks++;
      if (ALUResultM !== ev[i]) begin
        errors++;
        $display("FAIL alu_op_%h: got %h expected %h", ops[i], ALUResultM, ev[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_forwarding();
    ALUControlE = ALU_ADD; RegWriteE = 1'b1; RD_E = 5'd6;
    ForwardAE = FWD_RESW; ResultW = 32'd100; RD1_E = 32'd999;
    ForwardBE = 2'b11; RD2_E = 32'd5;
    step();
    checks++;
    if (ALUResultM !== 32'd105 || WriteDataM !== 32'd5) begin
      errors++;
      $display("FAIL fwd_resw: ALUResultM=%0d WriteDataM=%0d expected 105/5", ALUResultM, WriteDataM);
    end
    ALUControlE = ALU_SUB; ForwardAE = FWD_ALUM;
    ForwardBE = FWD_RESW; ResultW = 32'd1;
    step();
    checks++;
    if (ALUResultM !== 32'd104 || WriteDataM !== 32'd1) begin
      errors++;
      $display("FAIL fwd_alum: ALUResultM=%0d WriteDataM=%0d expected 104/1", ALUResultM, WriteDataM);
    end
    idle_inputs();
  endtask

  task automatic test_branch();
    BranchE = 1'b1; RD1_E = 32'd9; RD2_E = 32'd9;
    PCE = 32'h100; Imm_Ext_E = 32'h20; ALUSrcE = 1'b0;
    #1;
    checks++;
    if (PCSrcE !== 1'b1 || PCTargetE !== 32'h120) begin
      errors++;
      $display("FAIL branch_taken: PCSrcE=%b PCTargetE=%h expected 1/120", PCSrcE, PCTargetE);
    end
    RD2_E = 32'd8;
    #1;
    checks++;
    if (PCSrcE !== 1'b0) begin
      errors++;
      $display("FAIL branch_not_taken: got %b expected 0", PCSrcE);
    end
    PCE = 32'hFFFFFFF0;
    #1;
    checks++;
    if (PCTargetE !== 32'h10) begin
      errors++;
      $display("FAIL branch_wrap: got %h expected 00000010", PCTargetE);
    end
    checks++;
    if (BusyE !== 1'b0) begin
      errors++;
      $display("FAIL branch_busy: got %b expected 0", BusyE);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_mul_forward_stale();
    int busy_n, bub_bad;
    logic [31:0] res;
    logic rw;
    logic [4:0] rdm;
    ALUControlE = ALU_ADD; RD1_E = 32'hFFFFFFFF;
    ALUSrcE = 1'b1; Imm_Ext_E = '0;
    step();
    idle_inputs();
    do_multi(ALU_MUL, FWD_ALUM, 32'd0, 32'd3, 5'd7, busy_n, bub_bad, res, rw, rdm);
    checks++;
    if (busy_n !== 17) begin
      errors++;
      $display("FAIL mul_busy_cycles: got %0d expected 17", busy_n);
    end
    checks++;
    if (bub_bad !== 0) begin
      errors++;
      $display("FAIL mul_bubbles: %0d non-bubble cycles expected 0", bub_bad);
    end
    checks++;
    if (res !== 32'hFFFFFFFD || rw !== 1'b1 || rdm !== 5'd7) begin
      errors++;
      $display("FAIL mul_result: got %h/%b/%0d expected FFFFFFFD/1/7", res, rw, rdm);
    end
  endtask

  task automatic test_mac();
    int busy_n, bub_bad;
    logic [31:0] res;
    logic rw;
    logic [4:0] rdm;
    do_multi(ALU_MAC, FWD_RD, 32'd2, 32'd3, 5'd8, busy_n, bub_bad, res, rw, rdm);
    checks++;
    if (res !== 32'd6) begin
      errors++;
      $display("FAIL mac_first: got %0d expected 6", res);
    end
    do_multi(ALU_MAC, FWD_RD, 32'd4, 32'd5, 5'd8, busy_n, bub_bad, res, rw, rdm);
    checks++;
    if (res !== 32'd26 || busy_n !== 17) begin
      errors++;
      $display("FAIL mac_second: got %0d busy %0d expected 26 busy 17", res, busy_n);
    end
    ALUControlE = ALU_MACCLR; RegWriteE = 1'b1; RD_E = 5'd9;
    #1;
    checks++;
    if (BusyE !== 1'b0) begin
      errors++;
      $display("FAIL macclr_busy: got %b expected 0", BusyE);
    end
    step();
    checks++;
    if (ALUResultM !== 32'd26 || RD_M !== 5'd9) begin
      errors++;
      $display("FAIL macclr_result: got %0d rd %0d expected 26 rd 9", ALUResultM, RD_M);
    end
    step();
    checks++;
    if (ALUResultM !== 32'd0) begin
      errors++;
      $display("FAIL macclr_acc_zero: got %0d expected 0", ALUResultM);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_mac();
    int busy_n, bub_bad;
    logic [31:0] res;
    logic rw;
    logic [4:0] rdm;
    do_multi(ALU_MAC, FWD_RD, 32'd2, 32'd5, 5'd2, busy_n, bub_bad, res, rw, rdm);
    checks++;
    if (res !== 32'd10) begin
      errors++;
      $display("FAIL rstmid_setup: got %0d expected 10", res);
    end
    ALUControlE = ALU_MAC; RD1_E = 32'd3; RD2_E = 32'd3;
    RegWriteE = 1'b1; RD_E = 5'd2;
    for (int i = 0; i < 9; i++) step();
    rst = 1'b1;
    idle_inputs();
    RegWriteE = 1'b1; RD_E = 5'd12; PCPlus4E = 32'h300; RD1_E = 32'd7;
    step();
    checks++;
    if (BusyE !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_busy: got %b expected 0", BusyE);
    end
    checks++;
    if ({RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM,
         WriteDataM, PCPlus4M} !== '0) begin
      errors++;
      $display("FAIL rstmid_em: RegWriteM=%b RD_M=%0d ALUResultM=%h expected all 0",
               RegWriteM, RD_M, ALUResultM);
    end
    rst = 1'b0;
    idle_inputs();
    step();
    do_multi(ALU_MAC, FWD_RD, 32'd1, 32'd1, 5'd3, busy_n, bub_bad, res, rw, rdm);
    checks++;
    if (res !== 32'd1 || busy_n !== 17) begin
      errors++;
      $display("FAIL rstmid_mac_after: got %0d busy %0d expected 1 busy 17", res, busy_n);
    end
    ALUControlE = ALU_MACCLR;
    step();
    checks++;
    if (ALUResultM !== 32'd1) begin
      errors++;
      $display("FAIL rstmid_acc: got %0d expected 1", ALUResultM);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    int busy_n, bub_bad, b2, bb2;
    logic [31:0] res, res2;
    logic rw, rw2;
    logic [4:0] rdm, rdm2;
    do_multi(ALU_MUL, FWD_RD, 32'd6, 32'd7, 5'd1, busy_n, bub_bad, res, rw, rdm);
    do_multi(ALU_MUL, FWD_RD, 32'h12345678, 32'd16, 5'd2, b2, bb2, res2, rw2, rdm2);
    checks++;
    if (busy_n !== 17 || b2 !== 17) begin
      errors++;
      $display("FAIL b2b_busy: got %0d/%0d expected 17/17", busy_n, b2);
    end
    checks++;
    if (res !== 32'd42 || rw !== 1'b1 || rdm !== 5'd1) begin
      errors++;
      $display("FAIL b2b_first: got %0d/%b/%0d expected 42/1/1", res, rw, rdm);
    end
    checks++;
    if (bub_bad !== 0 || bb2 !== 0) begin
      errors++;
      $display("FAIL b2b_bubbles: got %0d/%0d expected 0/0", bub_bad, bb2);
    end
    checks++;
    if (res2 !== 32'h23456780 || rw2 !== 1'b1 || rdm2 !== 5'd2) begin
      errors++;
      $display("FAIL b2b_second: got %h/%b/%0d expected 23456780/1/2", res2, rw2, rdm2);
    end
    step();
    checks++;
    if (RegWriteM !== 1'b0 || RD_M !== 5'd0) begin
      errors++;
      $display("FAIL b2b_no_dup: RegWriteM=%b RD_M=%0d expected 0/0", RegWriteM, RD_M);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_add();
    test_alu_ops();
    test_forwarding();
    test_branch();
    test_mul_forward_stale();
    test_mac();
    test_reset_mid_mac();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
